pulse_capture: RTL

Parametrised capture buffer for tagged pulse-simulator output streams. It takes the single shared data bus plus one-hot channel enables produced by the pulse simulator, where channel 0 is truth and channel 1 is readout. Each channel's samples are queued separately, and fully aligned tuples (one sample per channel) are presented to a downstream consumer with a valid/read handshake. It replaces ad-hoc per-channel capture registers in simulation tops and FPGA tops, so no sample is lost when the consumer stalls.

---
 rtl/pulse_pkg.sv | 15 +
 rtl/pulse_capture_fifo.sv | 90 +++++++++
 rtl/pulse_capture.sv | 75 +++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared constants and the per-channel occupancy state used by the pulse
// capture buffer and its channel FIFOs.
package pulse_pkg;

    localparam int NUBITS_DEFAULT = 23;
    localparam int NCH_DEFAULT    = 2;
    localparam int CH_TRUTH       = 0;
    localparam int CH_READOUT     = 1;

    typedef enum logic {
        CH_EMPTY    = 1'b0,
        CH_NONEMPTY = 1'b1
    } chan_state_t;

endpackage

// File: rtl/pulse_capture_fifo.sv
// Single-channel show-ahead FIFO: the head word sits in a register, so dout
// is valid whenever the FIFO is non-empty and a pop exposes the next entry.
module pulse_capture_fifo
    import pulse_pkg::*;
#(
    parameter  int NUBITS = NUBITS_DEFAULT,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  logic [NUBITS-1:0] din,
    input  logic              rd,
    output logic [NUBITS-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [LW-1:0]     level
);

    logic [NUBITS-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     rd_ptr_next;
    logic [LW-1:0]     level_reg;
    logic [LW-1:0]     level_next;
    logic [NUBITS-1:0] dout_reg;
    logic [NUBITS-1:0] dout_next;
    chan_state_t       state;
    logic              rd_ok;
    logic              wr_ok;

    assign state       = (level_reg == '0) ? CH_EMPTY : CH_NONEMPTY;
    assign full        = (level_reg == LW'(DEPTH));
    assign rd_ok       = rd && (state == CH_NONEMPTY);
    // A pop frees the slot being written, so a full FIFO still accepts.
    assign wr_ok       = wr && (!full || rd_ok);
    assign rd_ptr_next = rd_ptr_reg + AW'(1);
    assign level_next  = level_reg + LW'(wr_ok) - LW'(rd_ok);

    always_comb begin
        dout_next = dout_reg;
        if (state == CH_EMPTY) begin
            if (wr_ok) begin
                dout_next = din;
            end
        end else if (rd_ok) begin
            // With one entry left the new head can only be this cycle's write.
            if (level_reg == LW'(1)) begin
                if (wr_ok) begin
                    dout_next = din;
                end
            end else begin
                dout_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst && !clr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            level_reg <= level_next;
            dout_reg  <= dout_next;
        end
    end

    assign dout  = dout_reg;
    assign empty = (state == CH_EMPTY);
    assign level = level_reg;

endmodule

// File: rtl/pulse_capture.sv
// Capture buffer for tagged pulse-simulator samples: one FIFO per channel,
// complete tuples presented with a valid/read handshake and sticky overflow.
module pulse_capture
    import pulse_pkg::*;
#(
    parameter  int NUBITS = NUBITS_DEFAULT,
    parameter  int NCH    = NCH_DEFAULT,
    parameter  int DEPTH  = 16,
    localparam int LW     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NCH-1:0]           in_en,
    input  logic signed [NUBITS-1:0] in_data,
    input  logic                     rd,
    output logic                     out_valid,
    output logic [NCH*NUBITS-1:0]    out_data,
    output logic [LW-1:0]            count,
    output logic [NCH-1:0]           ovf
);

    logic [NCH-1:0] empty;
    logic [NCH-1:0] full;
    logic [LW-1:0]  level [NCH];
    logic [LW-1:0]  count_min;
    logic [NCH-1:0] ovf_reg;
    logic           pop;

    assign out_valid = ~|empty;
    assign pop       = rd && out_valid;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            pulse_capture_fifo #(
                .NUBITS(NUBITS),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk  (clk),
                .rst  (rst),
                .clr  (clr),
                .wr   (in_en[gi]),
                .din  (in_data),
                .rd   (pop),
                .dout (out_data[gi*NUBITS +: NUBITS]),
                .empty(empty[gi]),
                .full (full[gi]),
                .level(level[gi])
            );
        end
    endgenerate

    always_comb begin
        count_min = level[0];
        for (int k = 1; k < NCH; k++) begin
            if (level[k] < count_min) begin
                count_min = level[k];
            end
        end
    end

    assign count = count_min;

    // A write into a full channel is lost only when no tuple pop frees a slot.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ovf_reg <= '0;
        end else begin
            ovf_reg <= ovf_reg | (in_en & full & {NCH{~pop}});
        end
    end

    assign ovf = ovf_reg;

endmodule
